// File: rtl/button_cond.sv
// Per-channel push-button conditioner: 2-flop synchronizer, debounce FSM, press/release/hold pulses.
// The release pulse port is named rel because release is a reserved word.
module button_cond #(
    parameter int unsigned NBTN            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned HOLD_CYCLES     = 12000000
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [NBTN-1:0] pb_in,
    output logic [NBTN-1:0] level,
    output logic [NBTN-1:0] press,
    output logic [NBTN-1:0] rel,
    output logic [NBTN-1:0] hold
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DB_DN = 2'd1,
        DOWN  = 2'd2,
        DB_UP = 2'd3
    } state_t;

    for (genvar i = 0; i < int'(NBTN); i++) begin : g_ch
        logic          meta;
        logic          sync;
        state_t        state, state_nx;
        logic [DW-1:0] dcnt, dcnt_nx;
        logic [HW-1:0] hcnt, hcnt_nx;
        logic          held, held_nx;
        logic          level_q, level_nx;
        logic          press_q, press_nx;
        logic          rel_q, rel_nx;
        logic          hold_q, hold_nx;

        // Two-flop synchronizer; only sync is used downstream.
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                meta <= 1'b0;
                sync <= 1'b0;
            end else begin
                meta <= pb_in[i];
                sync <= meta;
            end
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                state   <= UP;
                dcnt    <= '0;
                hcnt    <= '0;
                held    <= 1'b0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                hold_q  <= 1'b0;
            end else begin
                state   <= state_nx;
                dcnt    <= dcnt_nx;
                hcnt    <= hcnt_nx;
                held    <= held_nx;
                level_q <= level_nx;
                press_q <= press_nx;
                rel_q   <= rel_nx;
                hold_q  <= hold_nx;
            end
        end

        always_comb begin
            state_nx = state;
            dcnt_nx  = dcnt;
            hcnt_nx  = hcnt;
            held_nx  = held;
            level_nx = level_q;
            press_nx = 1'b0;
            rel_nx   = 1'b0;
            hold_nx  = 1'b0;
            case (state)
                UP: begin
                    if (sync) begin
                        state_nx = DB_DN;
                        dcnt_nx  = '0;
                    end
                end
                DB_DN: begin
                    if (!sync) begin
                        state_nx = UP;
                    end else if (dcnt == DB_LAST) begin
                        state_nx = DOWN;
                        press_nx = 1'b1;
                        level_nx = 1'b1;
                        hcnt_nx  = '0;
                        held_nx  = 1'b0;
                    end else begin
                        dcnt_nx = dcnt + DW'(1);
                    end
                end
                DOWN: begin
                    if (!sync) begin
                        state_nx = DB_UP;
                        dcnt_nx  = '0;
                    end else if (hcnt == HOLD_LAST) begin
                        // Counter saturates; the held flag limits hold to one pulse per press.
                        if (!held) begin
                            hold_nx = 1'b1;
                            held_nx = 1'b1;
                        end
                    end else begin
                        hcnt_nx = hcnt + HW'(1);
                    end
                end
                DB_UP: begin
                    if (sync) begin
                        state_nx = DOWN;
                    end else if (dcnt == DB_LAST) begin
                        state_nx = UP;
                        rel_nx   = 1'b1;
                        level_nx = 1'b0;
                    end else begin
                        dcnt_nx = dcnt + DW'(1);
                    end
                end
                default: state_nx = UP;
            endcase
        end

        assign level[i] = level_q;
        assign press[i] = press_q;
        assign rel[i]   = rel_q;
        assign hold[i]  = hold_q;
    end

endmodule

// File: doc/button_cond.md
BUTTON_COND -- requirements
Module: button_cond

Interface
REQ-001 Parameter NBTN, default 2, number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 120000, stable-input cycles needed to accept a level change (10 ms at 12 MHz).
REQ-003 Parameter HOLD_CYCLES, default 12000000, cycles a button stays accepted-pressed before the hold event fires (1 s at 12 MHz).
REQ-004 clk  input  1  single system clock; all state is on its rising edge.
REQ-005 nrst  input  1  reset, asynchronous and active-low.
REQ-006 pb_in  input  NBTN  raw active-high button pins, asynchronous to clk, may bounce.
REQ-007 level  output  NBTN  debounced button state, 1 = accepted pressed.
REQ-008 press  output  NBTN  one-cycle pulse on each accepted press, feeds the stopwatch pb0/pb1 inputs.
REQ-009 release  output  NBTN  one-cycle pulse on each accepted release.
REQ-010 hold  output  NBTN  one-cycle pulse once per press when held for HOLD_CYCLES, used as the long-press clear.

Function
REQ-011 Each channel SHALL be fully independent, with its own synchronizer, state machine, debounce counter and hold counter.
REQ-012 Each pb_in bit SHALL pass through a 2-flop synchronizer; only the second flop (sync) drives the state machine.
REQ-013 States per channel SHALL be UP, DB_DN, DOWN and DB_UP.
REQ-014 UP: sync=1 -> DB_DN with the debounce counter cleared to 0; otherwise stay.
REQ-015 DB_DN: sync=0 -> UP, no pulse (bounce rejected).
REQ-016 DB_DN: sync=1 and counter<DEBOUNCE_CYCLES-1 -> increment the counter.
REQ-017 DB_DN: sync=1 and counter==DEBOUNCE_CYCLES-1 -> DOWN; assert press for one cycle; set level=1; clear the hold counter and the held flag.
REQ-018 DOWN: sync=0 -> DB_UP with the debounce counter cleared.
REQ-019 DOWN: otherwise increment the hold counter, saturating at HOLD_CYCLES-1.
REQ-020 DB_UP: sync=1 -> DOWN; the hold counter and held flag are retained, not cleared.
REQ-021 DB_UP: sync=0 and counter==DEBOUNCE_CYCLES-1 -> UP; assert release for one cycle; set level=0.
REQ-022 DB_UP: sync=0 and counter<DEBOUNCE_CYCLES-1 -> increment the counter.
REQ-023 The hold pulse SHALL assert for one cycle when the hold counter reaches HOLD_CYCLES-1 in DOWN with held=0, and SHALL set held=1.
REQ-024 No further hold pulse SHALL fire until the next accepted press.
REQ-025 The hold counter SHALL not advance in DB_UP.
REQ-026 Latency: with pb_in high from clock edge 1 onward and no bounce, press SHALL be high for exactly the cycle following edge DEBOUNCE_CYCLES+3. Release latency SHALL be symmetric.
REQ-027 Hold SHALL pulse exactly HOLD_CYCLES edges after the edge that asserted press, provided no DB_UP excursion occurs.
REQ-028 press, release and hold SHALL be registered outputs, never combinational from pb_in.
REQ-029 press and release of one channel SHALL never be high in the same cycle.
REQ-030 Counter widths SHALL be $clog2 of the respective parameter. DEBOUNCE_CYCLES>=2 and HOLD_CYCLES>=2 are required.

Reset
REQ-031 nrst=0 SHALL immediately force all channels to UP, clear both synchronizer flops, clear all counters and held flags, and drive level, press, release and hold to 0.
REQ-032 Reset asserted mid-debounce or mid-hold SHALL discard all progress; no pulse SHALL be emitted as a result of reset.
REQ-033 A pin still high when nrst deasserts SHALL be treated as a new press and accepted only after the full synchronizer plus debounce latency.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, NBTN=2)
REQ-034 Clean press: pb_in[0] rises before edge 1 and stays high -> press[0] high only after edge 7, level[0]=1 from edge 7; no other outputs change.
REQ-035 Bounce: pb_in[0] high for 3 cycles, low 1, then high steady -> no pulse during the glitch; exactly one press[0] once 4 consecutive sync=1 cycles occur in DB_DN.
REQ-036 Long press: hold pb_in[0] high 30 cycles -> hold[0] pulses once, 10 edges after press[0]; no second hold pulse.
REQ-037 Release glitch: after hold[0], drop pb_in[0] for 2 cycles then restore -> no release, no second press, no second hold. A final steady low -> one release[0], level[0]=0.
REQ-038 Independence: both pins pressed with a 1-cycle offset -> press[0] and press[1] each fire once, offset by 1 cycle.
REQ-039 Reset mid-operation: nrst pulsed low while in DOWN with pin still high -> all outputs 0 immediately; press re-fires 7 edges after nrst release.
